// File: rtl/canny_window_ctrl.sv
// Frame sequencer for the Canny 3x3 window generator: handshakes pixels, tracks row/col and
// emits window-centre coordinates. Define CANNY_WIN_BORDER_EN to add the win_border output.
module canny_window_ctrl #(
  parameter int unsigned WIDTH = 640,
  parameter int unsigned DEPTH = 506,
  parameter int unsigned CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_fun,
  input  logic          frame_req,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          win_ready,
  output logic          start,
  output logic          data_en,
  output logic          win_valid,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col,
`ifdef CANNY_WIN_BORDER_EN
  output logic          win_border,
`endif
  output logic          frame_busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

  localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
  localparam logic [CW-1:0] RowLast = CW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic          active;
  logic          col_last;
  logic          win_take;

  // Assert asynchronously, release two clk edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  assign active     = (state_q == StFill) || (state_q == StRun);
  assign pix_ready  = active && win_ready && en_fun;
  assign data_en    = pix_valid && pix_ready;
  assign col_last   = (col_q == ColLast);
  assign start      = active;
  assign frame_busy = (state_q != StIdle);
  assign frame_done = (state_q == StDone);

`ifdef CANNY_WIN_BORDER_EN
  logic win_border_q, win_border_d;

  assign win_take   = data_en && (state_q == StRun);
  assign win_border = win_border_q;
`else
  assign win_take = data_en && (state_q == StRun) && (col_q >= CW'(2));
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;

    if (data_en) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle:  if (frame_req && en_fun) state_d = StFill;
      StFill:  if (data_en && col_last && (row_q == CW'(1))) state_d = StRun;
      StRun:   if (data_en && col_last && (row_q == RowLast)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over everything and never passes through DONE.
    if (!en_fun) begin
      state_d = StIdle;
    end
    if (state_d == StIdle) begin
      row_d = '0;
      col_d = '0;
    end
  end

  always_comb begin
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
`ifdef CANNY_WIN_BORDER_EN
    win_border_d = win_border_q;
    if (win_take) begin
      win_border_d = (col_q < CW'(2));
    end
`endif
    if (win_take) begin
      win_valid_d = 1'b1;
      win_row_d   = row_q - 1'b1;
      win_col_d   = col_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
`ifdef CANNY_WIN_BORDER_EN
      win_border_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
`ifdef CANNY_WIN_BORDER_EN
      win_border_q <= win_border_d;
`endif
    end
  end

  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule

// File: tb/tb_canny_window_ctrl.sv
// Directed bench for canny_window_ctrl at WIDTH=8, DEPTH=6; expected windows are queued per frame
// and popped by a monitor whenever win_valid is seen.
module tb_canny_window_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 6;
  localparam int unsigned CW = 10;
`ifdef CANNY_WIN_BORDER_EN
  localparam bit Border = 1'b1;
`else
  localparam bit Border = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] c;
    logic          b;
  } win_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en_fun = 1'b1;
  logic          frame_req = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic          win_ready = 1'b1;
  logic          start;
  logic          data_en;
  logic          win_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_busy;
  logic          frame_done;
`ifdef CANNY_WIN_BORDER_EN
  logic          win_border;
`endif

  int   checks = 0;
  int   errors = 0;
  win_t sb[$];
  win_t mon_w;
  bit   sb_on = 1'b1;

  canny_window_ctrl #(
    .WIDTH (W),
    .DEPTH (D),
    .CW    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_fun     (en_fun),
    .frame_req  (frame_req),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_ready  (win_ready),
    .start      (start),
    .data_en    (data_en),
    .win_valid  (win_valid),
    .win_row    (win_row),
    .win_col    (win_col),
`ifdef CANNY_WIN_BORDER_EN
    .win_border (win_border),
`endif
    .frame_busy (frame_busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window monitor: win_valid is registered, so sampling at negedge is stable.
  always @(negedge clk) begin
    if (sb_on && win_valid) begin
      if (sb.size() == 0) begin
        check("win_unexpected", {31'd0, win_valid}, 32'd0);
      end else begin
        mon_w = sb.pop_front();
        check("win_row", {22'd0, win_row}, {22'd0, mon_w.r});
        check("win_col", {22'd0, win_col}, {22'd0, mon_w.c});
`ifdef CANNY_WIN_BORDER_EN
        check("win_border", {31'd0, win_border}, {31'd0, mon_w.b});
`endif
      end
    end
  end

  // One frame with continuous pix_valid. abort_at>0 drops en_fun after that many accepts;
  // extra_req pulses frame_req during RUN (24th accept) and during DONE.
  task automatic run_frame(input bit toggle, input int abort_at, input bit extra_req);
    int   n;
    int   acc = 0;
    int   cyc = 0;
    bit   stop = 1'b0;
    bit   done_next = 1'b0;
    bit   abort_next = 1'b0;
    logic exp_rdy;
    win_t w;

    n = (abort_at != 0) ? abort_at : int'(W * D);
    for (int k = 0; k < n; k++) begin
      if ((k / W) >= 2 && (Border || (k % W) >= 2)) begin
        w.r = CW'((k / W) - 1);
        w.c = CW'((k % W) - 1);
        w.b = ((k % W) < 2);
        sb.push_back(w);
      end
    end

    pix_valid = 1'b1;
    @(negedge clk);
    frame_req = 1'b1;
    #1;
    check("busy_before_req", {31'd0, frame_busy}, 32'd0);
    @(negedge clk);
    frame_req = 1'b0;

    while (!stop && cyc < 1000) begin
      cyc++;
      if (abort_next) begin
        en_fun = 1'b0;
        stop   = 1'b1;
      end
      win_ready = toggle ? cyc[0] : 1'b1;
      frame_req = extra_req && (acc == 24 || done_next);
      #1;
      exp_rdy = !done_next && !abort_next && win_ready;
      check("frame_done", {31'd0, frame_done}, {31'd0, done_next});
      check("frame_busy", {31'd0, frame_busy}, 32'd1);
      check("start", {31'd0, start}, {31'd0, !done_next});
      check("pix_ready", {31'd0, pix_ready}, {31'd0, exp_rdy});
      check("data_en", {31'd0, data_en}, {31'd0, exp_rdy});
      if (done_next) stop = 1'b1;
      if (data_en) acc++;
      done_next  = data_en && (acc == int'(W * D));
      abort_next = data_en && (abort_at != 0) && (acc == abort_at);
      if (!stop) @(negedge clk);
    end
    check("frame_timeout", {31'd0, stop}, 32'd1);

    @(negedge clk);
    frame_req = 1'b0;
    #1;
    check("idle_busy", {31'd0, frame_busy}, 32'd0);
    check("idle_done", {31'd0, frame_done}, 32'd0);
    check("idle_start", {31'd0, start}, 32'd0);
    check("idle_win_valid", {31'd0, win_valid}, 32'd0);
    check("idle_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("accept_count", acc, n);
    en_fun = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("still_idle", {31'd0, frame_busy}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, frame_busy}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_win_valid", {31'd0, win_valid}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_win_row", {22'd0, win_row}, 32'd0);
    check("rst_win_col", {22'd0, win_col}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_frame(1'b0, 0, 1'b0);   // nominal frame
    run_frame(1'b1, 0, 1'b0);   // win_ready toggling
    run_frame(1'b0, 20, 1'b0);  // abort after 20th accept
    run_frame(1'b0, 0, 1'b0);   // full frame after abort
    run_frame(1'b0, 0, 1'b1);   // frame_req during RUN and DONE ignored

    // Reset in the middle of RUN.
    sb_on = 1'b0;
    pix_valid = 1'b1;
    win_ready = 1'b1;
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, frame_busy}, 32'd0);
    check("midrst_start", {31'd0, start}, 32'd0);
    check("midrst_win_valid", {31'd0, win_valid}, 32'd0);
    check("midrst_done", {31'd0, frame_done}, 32'd0);
    check("midrst_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("midrst_data_en", {31'd0, data_en}, 32'd0);
    check("midrst_win_row", {22'd0, win_row}, 32'd0);
    check("midrst_win_col", {22'd0, win_col}, 32'd0);
    sb.delete();
    // frame_req on the first edge after release must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    #1;
    check("release_req_ignored", {31'd0, frame_busy}, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("release_idle", {31'd0, frame_busy}, 32'd0);
    sb_on = 1'b1;
    run_frame(1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/canny_window_ctrl.md
CANNY_WINDOW_CTRL -- requirements
Module: canny_window_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640: pixels per row.
REQ-002 SHALL have parameter DEPTH, default 506: rows per frame.
REQ-003 SHALL have parameter CW, default 10: width of the row and column counters.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 en_fun  input  1  function enable; low aborts the frame.
REQ-007 frame_req  input  1  single-cycle pulse requesting one frame.
REQ-008 pix_valid  input  1  upstream pixel available.
REQ-009 pix_ready  output  1  controller accepts the pixel this cycle.
REQ-010 win_ready  input  1  downstream can accept a window.
REQ-011 start  output  1  high from frame_req acceptance until DONE; drives the window generator's start.
REQ-012 data_en  output  1  pixel-accept strobe to the window generator.
REQ-013 win_valid  output  1  3x3 window valid.
REQ-014 win_row, win_col  output  CW each  window centre coordinates.
REQ-015 frame_busy  output  1  state is not IDLE.
REQ-016 frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-017 FSM states SHALL be IDLE, FILL, RUN, DONE.
REQ-018 IDLE->FILL SHALL occur on frame_req && en_fun; frame_req SHALL be ignored outside IDLE.
REQ-019 pix_ready SHALL equal (state==FILL||state==RUN) && win_ready && en_fun, combinationally.
REQ-020 data_en SHALL equal pix_valid && pix_ready.
REQ-021 Counters col and row SHALL advance only on data_en; col SHALL wrap at WIDTH-1 to 0 and increment row.
REQ-022 FILL->RUN SHALL occur on acceptance of pixel (row 1, col WIDTH-1).
REQ-023 RUN->DONE SHALL occur on acceptance of pixel (DEPTH-1, WIDTH-1); DONE->IDLE SHALL occur unconditionally on the next cycle.
REQ-024 frame_done SHALL be high exactly during DONE.
REQ-025 win_valid SHALL be registered, asserting one cycle after a RUN data_en whose accepted pixel has col>=2.
REQ-026 win_row and win_col SHALL register the accepted pixel's row-1 and col-1 under the same condition, and hold otherwise.
REQ-027 Without a data_en, win_valid SHALL be 0 in the following cycle.
REQ-028 pix_valid high while pix_ready is low SHALL neither advance the counters nor assert data_en.
REQ-029 en_fun falling in any state SHALL force IDLE next cycle: counters cleared, start low, win_valid low, and no frame_done pulse.
REQ-030 frame_req coinciding with DONE SHALL be dropped.

Reset
REQ-031 On rst_n low: state IDLE, row=col=0, and start, win_valid, frame_done, win_row, win_col all 0, asynchronously.
REQ-032 Reset deassertion SHALL be synchronised; the first transition SHALL occur no earlier than the second clk edge after release.

Configuration
REQ-033 Macro CANNY_WIN_BORDER_EN SHALL add output win_border (1 bit).
REQ-034 With the macro, win_valid SHALL assert after every RUN data_en, with win_border=1 when the accepted col<2.
REQ-035 Without the macro, win_border SHALL be absent and REQ-025 applies unchanged.

Verification (WIDTH=8, DEPTH=6)
REQ-036 frame_req, continuous pix_valid, win_ready=1 -> 48 data_en; FILL->RUN after the 16th accept; exactly 24 win_valid; first window (1,1), last window (4,6); frame_done is 1 cycle after the 48th accept.
REQ-037 win_ready toggled every other cycle -> pix_ready follows it; the window count and sequence are unchanged; no pixel is accepted while win_ready=0.
REQ-038 en_fun dropped after the 20th accept -> IDLE next cycle, no frame_done; a new frame_req then yields a full 24-window frame.
REQ-039 frame_req pulsed during RUN and during DONE -> ignored; exactly one frame_done.
REQ-040 rst_n asserted mid-RUN -> all outputs are 0 immediately; after release, frame_busy stays 0 until frame_req.
REQ-041 With CANNY_WIN_BORDER_EN defined -> 32 win_valid, of which 8 have win_border=1.
